// File: rtl/axis_framer_pkg.sv
// axis_framer_pkg: state encoding, header layout and flag constants shared by the burst framer.
package axis_framer_pkg;
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DRAIN, TRAILER, DONE} state_t;
    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;
    localparam int SYNC_W = 16;
    localparam int SEQ_LSB = 16;
    localparam int FLAGS_W = 8;
    localparam int FLAG_TRUNC = 0;
    function automatic int ts_lsb(input int seq_w);
        return SEQ_LSB + seq_w;
    endfunction
    function automatic int flags_lsb(input int seq_w, input int ts_w);
        return SEQ_LSB + seq_w + ts_w;
    endfunction
endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry registered skid buffer; full throughput with a registered ready.
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             out_load;
    assign in_ready = !skid_valid;
    assign out_load = !out_valid || out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid && in_ready) begin
            // output stalled: park the accepted beat so ready can stay registered
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule

// File: rtl/axis_burst_framer.sv
// axis_burst_framer: wraps AXIS bursts into frames (sync/seq/timestamp header + payload), truncating overlong bursts.
// Define AXIS_BURST_FRAMER_TRAILER_EN to append a count/flags/XOR-fold trailer beat carrying tlast.
module axis_burst_framer
    import axis_framer_pkg::*;
#(
    parameter int          CHANNEL_WIDTH = 64,
    parameter int          MAX_BURST     = 32,
    parameter int          TS_WIDTH      = 48,
    parameter int          SEQ_WIDTH     = 16,
    parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    localparam int         DATA_WIDTH    = 4 * CHANNEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  trunc_pulse,
    output logic                  frame_active
);
    localparam int CW     = $clog2(MAX_BURST) + 1;
    localparam int TS_LSB = ts_lsb(SEQ_WIDTH);
    localparam int FL_LSB = flags_lsb(SEQ_WIDTH, TS_WIDTH);

    state_t                state, end_st;
    logic [TS_WIDTH-1:0]   ts, ts_lat;
    logic [SEQ_WIDTH-1:0]  seq;
    logic [CW-1:0]         cnt;
    logic                  trunc_flag, at_max, pay_hs;
    logic                  sk_valid, sk_ready, sk_last;
    logic [DATA_WIDTH-1:0] sk_data, hdr, trl;
    logic [DATA_WIDTH:0]   sk_out;
    logic [FLAGS_W-1:0]    flags;

`ifdef AXIS_BURST_FRAMER_TRAILER_EN
    localparam bit TRAILER_EN = 1'b1;
    logic [DATA_WIDTH-17:0] xacc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xacc <= '0;
        else if (state == DONE) xacc <= '0;
        else if (pay_hs) xacc <= xacc ^ s_axis_tdata[DATA_WIDTH-1:16];
    end
    assign trl = {xacc, flags, 8'(cnt)};
`else
    localparam bit TRAILER_EN = 1'b0;
    assign trl = '0;
`endif

    assign at_max = cnt == CW'(MAX_BURST - 1);
    assign pay_hs = state == PAYLOAD && s_axis_tvalid && sk_ready;
    assign end_st = TRAILER_EN ? TRAILER : DONE;

    always_comb begin
        flags             = '0;
        flags[FLAG_TRUNC] = trunc_flag;
        hdr                          = '0;
        hdr[SYNC_W-1:0]              = SYNC_WORD;
        hdr[SEQ_LSB +: SEQ_WIDTH]    = seq;
        hdr[TS_LSB +: TS_WIDTH]      = ts_lat;
        hdr[FL_LSB +: FLAGS_W]       = flags;
    end

    // header and trailer share the output stage with the payload stream
    assign sk_valid = state == HEADER || state == TRAILER || (state == PAYLOAD && s_axis_tvalid);
    assign sk_data  = state == HEADER ? hdr : state == TRAILER ? trl : s_axis_tdata;
    assign sk_last  = state == TRAILER || (!TRAILER_EN && state == PAYLOAD && (s_axis_tlast || at_max));
    assign s_axis_tready = state == PAYLOAD ? sk_ready : state == DRAIN;
    assign {m_axis_tlast, m_axis_tdata} = sk_out;

    axis_skid_buf #(.WIDTH(DATA_WIDTH + 1)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sk_valid),
        .in_ready  (sk_ready),
        .in_data   ({sk_last, sk_data}),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (sk_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else ts <= ts + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ts_lat       <= '0;
            seq          <= '0;
            cnt          <= '0;
            trunc_flag   <= 1'b0;
            trunc_pulse  <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            trunc_pulse <= 1'b0;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_active <= 1'b0;
            case (state)
                IDLE: if (s_axis_tvalid) begin
                    ts_lat <= ts;
                    state  <= HEADER;
                end
                HEADER: if (sk_ready) begin
                    trunc_flag   <= 1'b0;
                    frame_active <= 1'b1;
                    state        <= PAYLOAD;
                end
                PAYLOAD: if (pay_hs) begin
                    cnt <= cnt + 1'b1;
                    if (s_axis_tlast) state <= end_st;
                    else if (at_max) begin
                        trunc_pulse <= 1'b1;
                        trunc_flag  <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: if (s_axis_tvalid && s_axis_tlast) state <= end_st;
                TRAILER: if (sk_ready) state <= DONE;
                DONE: if (!m_axis_tvalid) begin
                    seq   <= seq + 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_burst_framer.sv
// tb_axis_burst_framer: table-driven burst vectors with a scoreboard of expected frame beats.
module tb_axis_burst_framer;
    localparam int CHW = 64, DW = 4 * CHW, MAXB = 32, TS_W = 48, SEQ_W = 4;
`ifdef AXIS_BURST_FRAMER_TRAILER_EN
    localparam int TR = 1;
`else
    localparam int TR = 0;
`endif

    typedef struct {
        int len;
        int rmode;
        int beats;
        int tp;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
    logic m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast, trunc_pulse, frame_active;

    int checks = 0, errors = 0, beats = 0, tp_cnt = 0, rmode = 0, rcnt = 0;
    logic [DW:0] q[$];
    logic [DW:0] hold;
    bit hold_v = 0;
    logic [TS_W-1:0] tb_ts;
    logic [SEQ_W-1:0] seq_m = '0;
    bit trunc_m = 0;
    vec_t vec[8];

    axis_burst_framer #(.CHANNEL_WIDTH(CHW), .MAX_BURST(MAXB), .TS_WIDTH(TS_W), .SEQ_WIDTH(SEQ_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .trunc_pulse   (trunc_pulse),
        .frame_active  (frame_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_ts <= '0;
        else tb_ts <= tb_ts + 1'b1;

    initial forever begin
        @(posedge clk);
        #1;
        rcnt++;
        m_axis_tready = rmode == 0 ? 1'b1 : rmode == 1 ? (rcnt % 4 == 0 || rcnt % 4 == 3) : 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr(input logic [SEQ_W-1:0] s, input logic [TS_W-1:0] t, input bit tr);
        logic [DW-1:0] h;
        h = '0;
        h[15:0] = 16'hA55A;
        h[16 +: SEQ_W] = s;
        h[16 + SEQ_W +: TS_W] = t;
        h[16 + SEQ_W + TS_W] = tr;
        return h;
    endfunction

    // must be called #1 after a posedge with the DUT idle so tb_ts is the timestamp it will latch
    task automatic send_burst(input int len, input int stop);
        logic [DW-1:0] d;
        logic [DW-17:0] xr;
        bit ok;
        int n;
        q.push_back({1'b0, hdr(seq_m, tb_ts, trunc_m)});
        trunc_m = 0;
        xr = '0;
        n = 0;
        for (int i = 0; i < len; i++) begin
            if (i == stop) break;
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tlast  = i == len - 1;
            ok = 0;
            for (int t = 0; t < 500 && !ok; t++) begin
                @(negedge clk);
                ok = s_axis_tready;
            end
            check("s_tready_wait", 64'(ok), 64'd1);
            if (i < MAXB) begin
                q.push_back({TR == 0 && (i == len - 1 || i == MAXB - 1), d});
                xr ^= d[DW-1:16];
                n++;
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (stop >= 0) return;
        trunc_m = len > MAXB;
        if (TR != 0) q.push_back({1'b1, xr, 7'd0, trunc_m, 8'(n)});
        seq_m++;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000 && q.size() != 0; t++) @(negedge clk);
        check("drain_queue_left", 64'(q.size()), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) hold_v = 0;
        else begin
            if (hold_v) begin
                checks++;
                if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== hold) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b %h expected %h", m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, hold);
                end
            end
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid) check("frame_active_with_valid", 64'(frame_active), 64'd1);
            if (trunc_pulse) tp_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got %h expected none", {m_axis_tlast, m_axis_tdata});
                end else begin
                    hold = q.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== hold) begin
                        errors++;
                        $display("FAIL out_beat got %h expected %h", {m_axis_tlast, m_axis_tdata}, hold);
                    end
                    hold = {m_axis_tlast, m_axis_tdata};
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int b0, t0;
        vec[0] = '{4, 0, 5 + TR, 0};
        vec[1] = '{4, 1, 5 + TR, 0};
        vec[2] = '{40, 0, 33 + TR, 1};
        vec[3] = '{1, 1, 2 + TR, 0};
        vec[4] = '{1, 0, 2 + TR, 0};
        vec[5] = '{32, 1, 33 + TR, 0};
        vec[6] = '{33, 0, 33 + TR, 1};
        vec[7] = '{31, 2, 32 + TR, 0};
        #23;
        check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_last", 64'(m_axis_tlast), 64'd0);
        check("rst_m_data", 64'(m_axis_tdata[63:0]), 64'd0);
        check("rst_trunc_pulse", 64'(trunc_pulse), 64'd0);
        check("rst_frame_active", 64'(frame_active), 64'd0);
        check("rst_s_ready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int v = 0; v < 8; v++) begin
            rmode = vec[v].rmode;
            b0 = beats;
            t0 = tp_cnt;
            send_burst(vec[v].len, -1);
            wait_drain();
            check($sformatf("v%0d_beats", v), 64'(beats - b0), 64'(vec[v].beats));
            check($sformatf("v%0d_trunc_pulses", v), 64'(tp_cnt - t0), 64'(vec[v].tp));
            check($sformatf("v%0d_frame_active_end", v), 64'(frame_active), 64'd0);
        end
        rmode = 0;
        for (int f = 0; f < 10; f++) begin
            send_burst(1, -1);
            wait_drain();
        end
        check("seq_wrap_frames", 64'(seq_m), 64'd2);
        send_burst(6, 3);
        check("pre_reset_valid", 64'(m_axis_tvalid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("abort_m_last", 64'(m_axis_tlast), 64'd0);
        check("abort_frame_active", 64'(frame_active), 64'd0);
        check("abort_s_ready", 64'(s_axis_tready), 64'd0);
        q.delete();
        seq_m = '0;
        trunc_m = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        b0 = beats;
        send_burst(2, -1);
        wait_drain();
        check("post_reset_beats", 64'(beats - b0), 64'(3 + TR));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
